// File: rtl/ser_word_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : ser_word_tx_if
//  Brief    : Load handshake and serial output bundle for ser_word_tx.
//             Carries ser_stall only when SER_STALL_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface ser_word_tx_if #(
   parameter int WIDTH = 8
);
   logic             load_valid;
   logic [WIDTH-1:0] load_data;
   logic             load_ready;
   logic             ser_out;
   logic             ser_valid;
   logic             frame_start;
   logic             frame_end;
   logic             busy;
`ifdef SER_STALL_EN
   logic             ser_stall;
`endif

   // Upstream producer / serial consumer side
   modport master (
      output load_valid,
      output load_data,
`ifdef SER_STALL_EN
      output ser_stall,
`endif
      input  load_ready,
      input  ser_out,
      input  ser_valid,
      input  frame_start,
      input  frame_end,
      input  busy
   );

   // Transmitter side
   modport slave (
      input  load_valid,
      input  load_data,
`ifdef SER_STALL_EN
      input  ser_stall,
`endif
      output load_ready,
      output ser_out,
      output ser_valid,
      output frame_start,
      output frame_end,
      output busy
   );
endinterface
`default_nettype wire

// File: rtl/ser_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : ser_word_tx
//  Brief    : Parallel-to-serial word transmitter, LSB first, with gapless
//             back-to-back words and frame_start/frame_end markers.
//             Optional macro SER_STALL_EN adds a ser_stall input that freezes
//             shifting while a word is in flight.
//  Revision : 1.0  initial release
// ============================================================================
module ser_word_tx #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst,    // asynchronous, active low
   ser_word_tx_if.slave  bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] shreg, shreg_nxt;
   logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
   logic             ser_out_q, ser_valid_q, frame_start_q, frame_end_q;
   logic             ser_out_nxt, ser_valid_nxt, frame_start_nxt, frame_end_nxt;
   logic             stall_act;
   logic             ready;
   logic             accept;

`ifdef SER_STALL_EN
   assign stall_act = bus.ser_stall & (state == SHIFT);
`else
   assign stall_act = 1'b0;
`endif

   // A word may be taken when idle or while the last bit is on the line
   assign ready  = rst & ~stall_act &
                   ((state == IDLE) | ((state == SHIFT) & (bit_cnt == LAST_BIT)));
   assign accept = bus.load_valid & ready;

   // Next-state, shift register and output decode
   always_comb begin
      state_nxt   = state;
      shreg_nxt   = shreg;
      bit_cnt_nxt = bit_cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt   = SHIFT;
               shreg_nxt   = bus.load_data;
               bit_cnt_nxt = '0;
            end
         end
         SHIFT: begin
            if (stall_act) begin
               state_nxt = SHIFT;
            end else if (bit_cnt != LAST_BIT) begin
               shreg_nxt   = shreg >> 1;
               bit_cnt_nxt = bit_cnt + 1'b1;
            end else if (accept) begin
               shreg_nxt   = bus.load_data;
               bit_cnt_nxt = '0;
            end else begin
               state_nxt   = IDLE;
               shreg_nxt   = '0;
               bit_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt   = IDLE;
            shreg_nxt   = '0;
            bit_cnt_nxt = '0;
         end
      endcase
      // Outputs are registered copies of the decode of the next state, so
      // they line up with the bit that the shift register will present.
      ser_out_nxt     = shreg_nxt[0];
      ser_valid_nxt   = (state_nxt == SHIFT);
      frame_start_nxt = (state_nxt == SHIFT) & (bit_cnt_nxt == '0);
      frame_end_nxt   = (state_nxt == SHIFT) & (bit_cnt_nxt == LAST_BIT);
   end

   // State, datapath and output registers with asynchronous clear
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         shreg         <= '0;
         bit_cnt       <= '0;
         ser_out_q     <= 1'b0;
         ser_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         frame_end_q   <= 1'b0;
      end else begin
         state         <= state_nxt;
         shreg         <= shreg_nxt;
         bit_cnt       <= bit_cnt_nxt;
         ser_out_q     <= ser_out_nxt;
         ser_valid_q   <= ser_valid_nxt;
         frame_start_q <= frame_start_nxt;
         frame_end_q   <= frame_end_nxt;
      end
   end

   assign bus.load_ready  = ready;
   assign bus.ser_out     = ser_out_q;
   assign bus.ser_valid   = ser_valid_q;
   assign bus.frame_start = frame_start_q;
   assign bus.frame_end   = frame_end_q;
   assign bus.busy        = ser_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_ser_word_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ser_word_tx
//  Brief    : Self-checking bench for ser_word_tx (WIDTH = 8) with a bit-level
//             scoreboard and a serial two's-complement reference stage.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ser_word_tx;
   localparam int WIDTH = 8;

   typedef struct packed {
      logic bitv;
      logic fs;
      logic fe;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic stall = 1'b0;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];

   // serial two's-complement reference stage, re-armed by frame_start
   logic       tc_seen1 = 1'b0;
   logic [7:0] tc_cap   = 8'h00;

   ser_word_tx_if #(.WIDTH(WIDTH)) bus ();

   ser_word_tx #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef SER_STALL_EN
   assign bus.ser_stall = stall;
`endif

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: compare the presented bit, then enqueue any word
   // that will be accepted at the coming rising edge.
   always @(negedge clk) begin
      logic stall_now;
      logic b, o, s1;
`ifdef SER_STALL_EN
      stall_now = stall;
`else
      stall_now = 1'b0;
`endif
      if (rst) begin
         check("ser_valid", 32'(bus.ser_valid), 32'(sb.size() != 0));
         check("busy", 32'(bus.busy), 32'(bus.ser_valid));
         if (sb.size() != 0 && bus.ser_valid) begin
            check("ser_out", 32'(bus.ser_out), 32'(sb[0].bitv));
            check("frame_start", 32'(bus.frame_start), 32'(sb[0].fs));
            check("frame_end", 32'(bus.frame_end), 32'(sb[0].fe));
            if (!stall_now) begin
               b  = bus.ser_out;
               s1 = bus.frame_start ? 1'b0 : tc_seen1;
               o  = s1 ? ~b : b;
               tc_seen1 = s1 | b;
               tc_cap   = {o, tc_cap[7:1]};
               void'(sb.pop_front());
            end
         end
         if (bus.load_valid && bus.load_ready) begin
            for (int i = 0; i < WIDTH; i++)
               sb.push_back('{bitv: bus.load_data[i], fs: (i == 0), fe: (i == WIDTH - 1)});
         end
      end
   end

   // Present a word and return #1 after the edge that accepts it
   task automatic send(input logic [7:0] d);
      bit ok = 1'b0;
      bus.load_valid = 1'b1;
      bus.load_data  = d;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         if (bus.load_ready) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      check("send_timeout", 32'(ok), 32'd1);
   endtask

   task automatic wait_idle();
      bit ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         if (sb.size() == 0 && !bus.ser_valid) ok = 1'b1;
      end
      check("idle_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      bus.load_valid = 1'b1;
      bus.load_data  = 8'hFF;
      // Reset state, with load_valid high to show load_ready is forced low
      #3;
      check("rst_ser_out", 32'(bus.ser_out), 32'd0);
      check("rst_ser_valid", 32'(bus.ser_valid), 32'd0);
      check("rst_frames", 32'({bus.frame_start, bus.frame_end}), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_load_ready", 32'(bus.load_ready), 32'd0);
      bus.load_valid = 1'b0;
      #9 rst = 1'b1;
      @(posedge clk); #1;
      check("idle_load_ready", 32'(bus.load_ready), 32'd1);

      // Basic word, also fed through the two's-complement reference
      send(8'b0011_0110);
      bus.load_valid = 1'b0;
      wait_idle();
      check("chain_result", 32'(tc_cap), 32'hCA);
      check("post_word_ready", 32'(bus.load_ready), 32'd1);
      check("post_word_out", 32'(bus.ser_out), 32'd0);

      // Back-to-back: second send completes on the last bit of the first
      send(8'hA5);
      send(8'h3C);
      bus.load_valid = 1'b0;
      wait_idle();

      // Handshake: varying data during bits 0..6 must be ignored
      send(8'hFF);
      for (int i = 0; i < 7; i++) begin
         bus.load_data = 8'($urandom);
         @(negedge clk);
         check("busy_not_ready", 32'(bus.load_ready), 32'd0);
         @(posedge clk); #1;
      end
      bus.load_data = 8'h81;
      @(negedge clk);
      check("last_bit_ready", 32'(bus.load_ready), 32'd1);
      @(posedge clk); #1;
      bus.load_valid = 1'b0;
      wait_idle();

      // Reset mid-word: asynchronous clear during bit 3
      send(8'hF0);
      bus.load_valid = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      check("pre_abort_out", 32'(bus.ser_out), 32'd0);
      #2 rst = 1'b0;
      sb.delete();
      #1;
      check("abort_valid", 32'(bus.ser_valid), 32'd0);
      check("abort_frames", 32'({bus.frame_start, bus.frame_end, bus.busy}), 32'd0);
      check("abort_ready", 32'(bus.load_ready), 32'd0);
      #4 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_resume", 32'(bus.ser_valid), 32'd0);

`ifdef SER_STALL_EN
      // Stall three cycles while bit 2 of 8'h55 is presented
      send(8'h55);
      bus.load_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_out", 32'({bus.ser_valid, bus.ser_out}), 32'b11);
         check("stall_ready", 32'(bus.load_ready), 32'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      check("stall_out_last", 32'({bus.ser_valid, bus.ser_out}), 32'b11);
      wait_idle();
`endif

      // A few random words streamed back to back
      for (int k = 0; k < 4; k++) send(8'($urandom));
      bus.load_valid = 1'b0;
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
